// File: rtl/usbfs_tx_pkt_if.sv
`default_nettype none
// ============================================================================
// Module      : usbfs_tx_pkt_if
// Description : Bundle of request, endpoint-buffer-write and serializer
//               byte-stream signals for the USB FS packet transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
interface usbfs_tx_pkt_if #(
    parameter int MAX_PKT = 8
);
    localparam int IDX_W = $clog2(MAX_PKT);

    // Transaction FSM request side
    logic             i_txReq;
    logic [3:0]       i_txPid;
    logic             o_txIdle;
    logic             o_etTxAccepted;

    // Endpoint buffer write side
    logic             i_etWrEn;
    logic [IDX_W-1:0] i_etWrIdx;
    logic [7:0]       i_etWrByte;

    // Byte stream towards the bit serializer
    logic             o_valid;
    logic             i_ready;
    logic [7:0]       o_data;
    logic             o_sop;
    logic             o_eop;

    // Packet transmitter side
    modport slave (
        input  i_txReq, i_txPid, i_etWrEn, i_etWrIdx, i_etWrByte, i_ready,
        output o_txIdle, o_etTxAccepted, o_valid, o_data, o_sop, o_eop
    );

    // Transaction FSM / serializer side
    modport master (
        output i_txReq, i_txPid, i_etWrEn, i_etWrIdx, i_etWrByte, i_ready,
        input  o_txIdle, o_etTxAccepted, o_valid, o_data, o_sop, o_eop
    );
endinterface
`default_nettype wire

// File: rtl/usbfs_tx_pkt.sv
`default_nettype none
// ============================================================================
// Module      : usbfs_tx_pkt
// Description : USB full-speed packet transmitter. Sends handshake packets
//               (PID only) or data packets (PID, buffered payload, CRC16)
//               as a byte stream with valid/ready flow control.
// Revision    : 1.0 - initial release
// ============================================================================
module usbfs_tx_pkt #(
    parameter int MAX_PKT = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    usbfs_tx_pkt_if.slave  bus
);
    localparam int IDX_W = $clog2(MAX_PKT);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PKT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PID   = 3'd1,
        S_FILL  = 3'd2,
        S_DATA  = 3'd3,
        S_CRCLO = 3'd4,
        S_CRCHI = 3'd5
    } state_t;

    state_t           state;
    logic [3:0]       pid;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] rd_idx;
    logic [15:0]      crc;
    logic             tx_idle;
    logic             valid;
    logic             sop;
    logic             eop;
    logic [7:0]       data;
    logic [7:0]       buffer [MAX_PKT];

    // One CRC16 byte step, LSB first, reflected polynomial 0xA001.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    logic             hs;
    logic             is_data;
    logic             wr_fire;
    logic [CNT_W-1:0] next_count;
    logic             fill_done;
    logic [7:0]       first_byte;
    logic [15:0]      crc_next;
    logic [IDX_W-1:0] nxt_idx;
    logic             last_byte;

    assign hs         = valid && bus.i_ready;
    assign is_data    = (pid[1:0] == 2'b11);
    assign wr_fire    = (state == S_FILL) && bus.i_etWrEn && (count != MAX_CNT) && !i_rst;
    assign next_count = wr_fire ? (count + CNT_W'(1)) : count;
    assign fill_done  = !bus.i_etWrEn || (next_count == MAX_CNT);
    // Byte 0 may be written on the very cycle FILL exits, so forward it.
    assign first_byte = (wr_fire && (bus.i_etWrIdx == '0)) ? bus.i_etWrByte : buffer[0];
    assign crc_next   = crc16_byte(crc, data);
    assign nxt_idx    = rd_idx + IDX_W'(1);
    assign last_byte  = (({1'b0, rd_idx} + CNT_W'(1)) == count);

    assign bus.o_txIdle       = tx_idle;
    assign bus.o_valid        = valid;
    assign bus.o_sop          = sop;
    assign bus.o_eop          = eop;
    assign bus.o_data         = data;
    // Pulse coincides with the handshake that hands the DATAx PID downstream.
    assign bus.o_etTxAccepted = (state == S_PID) && is_data && hs;

    // Payload buffer write port; contents intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (wr_fire) buffer[bus.i_etWrIdx] <= bus.i_etWrByte;
    end

    // Packet sequencing FSM with registered stream outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= S_IDLE;
            pid     <= 4'h0;
            count   <= '0;
            rd_idx  <= '0;
            crc     <= 16'hFFFF;
            tx_idle <= 1'b1;
            valid   <= 1'b0;
            sop     <= 1'b0;
            eop     <= 1'b0;
            data    <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_txReq) begin
                        pid     <= bus.i_txPid;
                        tx_idle <= 1'b0;
                        valid   <= 1'b1;
                        sop     <= 1'b1;
                        eop     <= (bus.i_txPid[1:0] != 2'b11);
                        data    <= {~bus.i_txPid, bus.i_txPid};
                        state   <= S_PID;
                    end
                end
                S_PID: begin
                    if (hs) begin
                        valid <= 1'b0;
                        sop   <= 1'b0;
                        eop   <= 1'b0;
                        if (is_data) begin
                            count <= '0;
                            crc   <= 16'hFFFF;
                            state <= S_FILL;
                        end else begin
                            tx_idle <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                S_FILL: begin
                    count <= next_count;
                    if (fill_done) begin
                        valid <= 1'b1;
                        if (next_count != '0) begin
                            rd_idx <= '0;
                            data   <= first_byte;
                            state  <= S_DATA;
                        end else begin
                            data  <= ~crc[7:0];
                            state <= S_CRCLO;
                        end
                    end
                end
                S_DATA: begin
                    if (hs) begin
                        crc <= crc_next;
                        if (last_byte) begin
                            data  <= ~crc_next[7:0];
                            state <= S_CRCLO;
                        end else begin
                            rd_idx <= nxt_idx;
                            data   <= buffer[nxt_idx];
                        end
                    end
                end
                S_CRCLO: begin
                    if (hs) begin
                        data  <= ~crc[15:8];
                        eop   <= 1'b1;
                        state <= S_CRCHI;
                    end
                end
                S_CRCHI: begin
                    if (hs) begin
                        valid   <= 1'b0;
                        eop     <= 1'b0;
                        tx_idle <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    tx_idle <= 1'b1;
                    valid   <= 1'b0;
                    sop     <= 1'b0;
                    eop     <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: doc/usbfs_tx_pkt.md
USBFS_TX_PKT -- requirements
Module: usbfs_tx_pkt

Interface
REQ-001 SHALL have parameter MAX_PKT, default 8, meaning packet buffer depth in bytes (power of 2, >=2).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_txReq  input  1  transaction FSM requests a packet send.
REQ-005 SHALL have port i_txPid  input  4  PID nibble for requested packet.
REQ-006 SHALL have port o_txIdle  output  1  block idle; request accepted when i_txReq && o_txIdle.
REQ-007 SHALL have port o_etTxAccepted  output  1  one-cycle pulse when a DATA0/DATA1 PID byte is taken downstream.
REQ-008 SHALL have port i_etWrEn  input  1  endpoint buffer write strobe.
REQ-009 SHALL have port i_etWrIdx  input  $clog2(MAX_PKT)  buffer write index.
REQ-010 SHALL have port i_etWrByte  input  8  buffer write data.
REQ-011 SHALL have port o_valid  output  1  byte valid to bit serializer.
REQ-012 SHALL have port i_ready  input  1  serializer takes byte when o_valid && i_ready.
REQ-013 SHALL have port o_data  output  8  byte to serializer, LSB transmitted first.
REQ-014 SHALL have port o_sop  output  1  qualifies o_data as first byte of packet.
REQ-015 SHALL have port o_eop  output  1  qualifies o_data as last byte of packet.

Function
REQ-016 SHALL implement states IDLE, PID, FILL, DATA, CRCLO, CRCHI.
REQ-017 SHALL in IDLE drive o_txIdle=1, o_valid=0; on accepted request latch i_txPid, go PID next cycle.
REQ-018 SHALL in PID drive o_valid=1, o_sop=1, o_data={~pid,pid} (DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E).
REQ-019 SHALL, for non-DATA PID (pid[1:0]!=2'b11), drive o_eop=1 in PID and return to IDLE on handshake.
REQ-020 SHALL, for DATA0/DATA1 PID, on handshake pulse o_etTxAccepted for exactly that cycle, clear byte count and CRC register (0xFFFF), go FILL.
REQ-021 SHALL in FILL write i_etWrByte into buffer[i_etWrIdx] and increment count on each i_etWrEn; o_valid=0.
REQ-022 SHALL leave FILL on first cycle after the o_etTxAccepted cycle in which i_etWrEn=0, or when count reaches MAX_PKT.
REQ-023 SHALL go DATA if count>0, else CRCLO (zero-length packet).
REQ-024 SHALL in DATA emit buffer[0..count-1] in index order, one byte per handshake, updating CRC on each handshake; go CRCLO after last byte.
REQ-025 SHALL compute CRC16 LSB-first, reflected polynomial 0xA001, init 0xFFFF; transmitted CRC = ~register.
REQ-026 SHALL in CRCLO emit ~crc[7:0], in CRCHI emit ~crc[15:8] with o_eop=1; return to IDLE on CRCHI handshake.
REQ-027 SHALL hold o_data, o_sop, o_eop stable while o_valid && !i_ready; o_sop/o_eop SHALL be 0 when o_valid=0.
REQ-028 SHALL ignore i_etWrEn outside FILL; SHALL ignore i_txReq when o_txIdle=0.
REQ-029 SHALL keep byte count width $clog2(MAX_PKT)+1 so count==MAX_PKT is representable without wrap.
REQ-030 SHALL accept a new request in the same cycle o_txIdle is asserted following a packet end (no dead cycle required beyond IDLE).

Reset
REQ-031 SHALL on i_rst (any state, mid-packet included) enter IDLE next cycle: o_txIdle=1, o_valid=0, o_sop=0, o_eop=0, o_etTxAccepted=0, count=0, CRC=0xFFFF.
REQ-032 SHALL NOT reset buffer contents; buffer values SHALL be unobservable until rewritten.

Verification
REQ-033 SHALL cover: request PID 0x2, i_ready=1 -> single byte 0xD2 with o_sop=o_eop=1, back to IDLE, no o_etTxAccepted.
REQ-034 SHALL cover: request PID 0x3, no writes -> bytes 0xC3, 0x00, 0x00; eop on last; one o_etTxAccepted pulse.
REQ-035 SHALL cover: PID 0xB, writes 0x00,0x01,0x02,0x03 on consecutive cycles after pulse -> 0x4B, 0x00..0x03, two CRC bytes; CRC16 over payload+CRC bytes yields register residual 0xB001.
REQ-036 SHALL cover: MAX_PKT+2 consecutive writes -> FILL exits at count=MAX_PKT, exactly MAX_PKT payload bytes emitted.
REQ-037 SHALL cover: random i_ready backpressure -> byte sequence identical to i_ready=1 case, outputs stable while stalled.
REQ-038 SHALL cover: i_rst asserted in DATA mid-packet -> IDLE next cycle, all outputs per REQ-031, next request sends correct packet.
